// File: rtl/hazard_scheduler_pkg.sv
// Shared encodings for the 5-stage hazard controller: forward selects,
// result-source codes, MDU sequencer states and the forwarding rule.
package hazard_scheduler_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [1:0] RES_MEM = 2'b01;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } mdu_state_e;

   // M beats W because it holds the younger write; x0 is hardwired zero.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] rd_m,
      input logic       regwrite_m,
      input logic [4:0] rd_w,
      input logic       regwrite_w
   );
      if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs)) return FWD_MEM;
      if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_WB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_scheduler_mdu_sequencer.sv
// Multi-cycle MDU launcher: issues the start pulse, holds the front of the
// pipe until mdu_done, and releases on a watchdog timeout.
module mdu_sequencer
   import hazard_scheduler_pkg::*;
#(
   parameter int MDU_TIMEOUT = 64,
   parameter int CNT_W       = $clog2(MDU_TIMEOUT) + 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic mdu_req_e,
   input  logic pcsrc_e,
   input  logic mdu_done,
   output logic mdu_start,
   output logic mdu_hold,
   output logic mdu_busy,
   output logic mdu_timeout
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MDU_TIMEOUT);

   mdu_state_e       state;
   mdu_state_e       next_state;
   logic [CNT_W-1:0] cnt;
   logic             start_raw;
   logic             hold_raw;
   logic             timeout_set;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      next_state  = state;
      start_raw   = 1'b0;
      hold_raw    = 1'b0;
      timeout_set = 1'b0;
      case (state)
         IDLE: begin
            if (mdu_req_e && !pcsrc_e) begin
               start_raw  = 1'b1;
               hold_raw   = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            if (mdu_done) begin
               next_state = IDLE;
            end else if (cnt == CNT_LAST) begin
               timeout_set = 1'b1;
               next_state  = IDLE;
            end else begin
               hold_raw = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, matching the hardware.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         mdu_timeout <= 1'b0;
      end else begin
         state <= next_state;
         if (start_raw) begin
            cnt <= '0;
         end else if ((state == RUN) && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (timeout_set) begin
            mdu_timeout <= 1'b1;
         end
      end
   end

   // The next state is ignored while reset is low, so the pulses are gated too.
   assign mdu_start = start_raw & rst_n;
   assign mdu_hold  = hold_raw & rst_n;
   assign mdu_busy  = (state == RUN);

endmodule

// File: rtl/hazard_scheduler.sv
// Hazard controller for the F/D/E/M/W core: operand forwarding, load-use
// stalls, branch flushes and MDU pipeline freezing.
module hazard_scheduler
   import hazard_scheduler_pkg::*;
#(
   parameter int MDU_TIMEOUT = 64,
   parameter int CNT_W       = $clog2(MDU_TIMEOUT) + 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] rs1_d,
   input  logic [4:0] rs2_d,
   input  logic [4:0] rs1_e,
   input  logic [4:0] rs2_e,
   input  logic [4:0] rd_e,
   input  logic [1:0] resultsrc_e,
   input  logic [4:0] rd_m,
   input  logic       regwrite_m,
   input  logic [4:0] rd_w,
   input  logic       regwrite_w,
   input  logic       pcsrc_e,
   input  logic       mdu_req_e,
   input  logic       mdu_done,
   output logic [1:0] forward_a_e,
   output logic [1:0] forward_b_e,
   output logic       stall_f,
   output logic       stall_d,
   output logic       stall_e,
   output logic       flush_d,
   output logic       flush_e,
   output logic       flush_m,
   output logic       mdu_start,
   output logic       mdu_busy,
   output logic       mdu_timeout
);

   logic lw_stall;
   logic mdu_hold;

   assign forward_a_e = fwd_sel(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
   assign forward_b_e = fwd_sel(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);

   assign lw_stall = (resultsrc_e == RES_MEM) && (rd_e != 5'd0) &&
                     ((rd_e == rs1_d) || (rd_e == rs2_d));

   mdu_sequencer #(
      .MDU_TIMEOUT (MDU_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_mdu_sequencer (
      .clk         (clk),
      .rst_n       (rst_n),
      .mdu_req_e   (mdu_req_e),
      .pcsrc_e     (pcsrc_e),
      .mdu_done    (mdu_done),
      .mdu_start   (mdu_start),
      .mdu_hold    (mdu_hold),
      .mdu_busy    (mdu_busy),
      .mdu_timeout (mdu_timeout)
   );

   // The MDU hold keeps its instruction in E, so it masks branch and load-use flushes.
   assign stall_f = rst_n & (lw_stall | mdu_hold);
   assign stall_d = rst_n & (lw_stall | mdu_hold);
   assign stall_e = rst_n & mdu_hold;
   assign flush_m = rst_n & mdu_hold;
   assign flush_d = rst_n & pcsrc_e & ~mdu_hold;
   assign flush_e = rst_n & (lw_stall | pcsrc_e) & ~mdu_hold;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler: directed scenarios then random
// traffic, checked against a cycle-indexed behavioural model.
module tb_hazard_scheduler;
   import hazard_scheduler_pkg::*;

   localparam int TMO = 8;
   localparam int CW  = $clog2(TMO) + 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0, rd_e = '0;
   logic [1:0] resultsrc_e = '0;
   logic [4:0] rd_m = '0, rd_w = '0;
   logic       regwrite_m = 1'b0, regwrite_w = 1'b0;
   logic       pcsrc_e = 1'b0, mdu_req_e = 1'b0, mdu_done = 1'b0;
   logic [1:0] forward_a_e, forward_b_e;
   logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
   logic       mdu_start, mdu_busy, mdu_timeout;

   always #5 clk = ~clk;

   hazard_scheduler #(.MDU_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
      .rd_e(rd_e), .resultsrc_e(resultsrc_e),
      .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
      .pcsrc_e(pcsrc_e), .mdu_req_e(mdu_req_e), .mdu_done(mdu_done),
      .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
      .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
      .mdu_start(mdu_start), .mdu_busy(mdu_busy), .mdu_timeout(mdu_timeout)
   );

   typedef struct packed {
      logic       rst_n;
      logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
      logic [1:0] resultsrc_e;
      logic [4:0] rd_m;
      logic       regwrite_m;
      logic [4:0] rd_w;
      logic       regwrite_w;
      logic       pcsrc_e, mdu_req_e, mdu_done;
   } stim_t;

   typedef struct packed {
      logic [1:0] fa, fb;
      logic [2:0] stall;   // {f, d, e}
      logic [2:0] flush;   // {d, e, m}
      logic       start, busy, tmo;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   n_start  = 0, n_hold = 0, n_busy = 0;

   // Reference state: cycle index of the in-flight MDU launch (-1 = none).
   int   op_start = -1;
   bit   tmo_flag = 1'b0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic stim_t idle_stim();
      stim_t s = '0;
      s.rst_n = 1'b1;
      return s;
   endfunction

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
      logic [1:0] r;
      r = 2'b00;
      if (rs != 5'd0) begin
         if (s.regwrite_w && s.rd_w == rs) r = 2'b01;
         if (s.regwrite_m && s.rd_m == rs) r = 2'b10;
      end
      return r;
   endfunction

   task automatic model(input stim_t s, output exp_t e);
      bit hold, start, lw;
      bit in_flight;
      e = '0;
      e.fa = ref_fwd(s.rs1_e, s);
      e.fb = ref_fwd(s.rs2_e, s);
      if (!s.rst_n) begin
         op_start = -1;
         tmo_flag = 1'b0;
         return;
      end
      in_flight = (op_start >= 0);
      e.busy = in_flight;
      e.tmo  = tmo_flag;
      hold  = 1'b0;
      start = 1'b0;
      if (!in_flight) begin
         if (s.mdu_req_e && !s.pcsrc_e) begin
            start    = 1'b1;
            hold     = 1'b1;
            op_start = cyc;
         end
      end else if (s.mdu_done) begin
         op_start = -1;
      end else if (cyc - op_start == TMO) begin
         tmo_flag = 1'b1;
         op_start = -1;
      end else begin
         hold = 1'b1;
      end
      lw = (s.resultsrc_e == 2'b01) && (s.rd_e != 0) &&
           (s.rd_e == s.rs1_d || s.rd_e == s.rs2_d);
      e.stall = {lw | hold, lw | hold, hold};
      e.flush = {s.pcsrc_e & ~hold, (lw | s.pcsrc_e) & ~hold, hold};
      e.start = start;
   endtask

   task automatic step(input stim_t s);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = s.rst_n; rs1_d = s.rs1_d; rs2_d = s.rs2_d;
      rs1_e = s.rs1_e; rs2_e = s.rs2_e; rd_e = s.rd_e;
      resultsrc_e = s.resultsrc_e; rd_m = s.rd_m; regwrite_m = s.regwrite_m;
      rd_w = s.rd_w; regwrite_w = s.regwrite_w;
      pcsrc_e = s.pcsrc_e; mdu_req_e = s.mdu_req_e; mdu_done = s.mdu_done;
      model(s, e);
      exp_q.push_back(e);
      cyc++;
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      check("drain", 16'(exp_q.size()), 16'd0);
   endtask

   // Monitor: compares the sampled DUT outputs with the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("fwd",   16'({forward_a_e, forward_b_e}), 16'({e.fa, e.fb}));
            check("stall", 16'({stall_f, stall_d, stall_e}), 16'(e.stall));
            check("flush", 16'({flush_d, flush_e, flush_m}), 16'(e.flush));
            check("mdu",   16'({mdu_start, mdu_busy, mdu_timeout}),
                  16'({e.start, e.busy, e.tmo}));
            n_start += int'(mdu_start);
            n_hold  += int'(stall_e);
            n_busy  += int'(mdu_busy);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      stim_t s;
      s = idle_stim(); s.rst_n = 1'b0;
      step(s); step(s);

      // Forwarding priority and x0.
      s = idle_stim();
      s.rd_m = 5; s.regwrite_m = 1; s.rd_w = 5; s.regwrite_w = 1; s.rs1_e = 5; s.rs2_e = 5;
      step(s);
      s.regwrite_m = 0; step(s);
      s.rs1_e = 0; s.rd_m = 0; s.rd_w = 0; step(s);

      // Load-use, then the same with rd_e = x0.
      s = idle_stim();
      s.resultsrc_e = 2'b01; s.rd_e = 7; s.rs2_d = 7; step(s);
      s.rd_e = 0; s.rs2_d = 0; step(s);

      // Taken branch for one cycle.
      s = idle_stim(); s.pcsrc_e = 1; step(s);
      s.pcsrc_e = 0; step(s);
      drain();

      // MDU op with done four cycles after start.
      n_start = 0; n_hold = 0; n_busy = 0;
      s = idle_stim(); s.mdu_req_e = 1;
      for (int i = 0; i < 4; i++) step(s);
      s.mdu_done = 1; step(s);
      s = idle_stim(); step(s);
      drain();
      check("start_pulses", 16'(n_start), 16'd1);
      check("hold_cycles",  16'(n_hold),  16'd4);
      check("busy_cycles",  16'(n_busy),  16'd4);

      // Watchdog timeout, then stickiness.
      n_hold = 0;
      s = idle_stim(); s.mdu_req_e = 1;
      for (int i = 0; i < TMO + 1; i++) step(s);
      s = idle_stim();
      for (int i = 0; i < 3; i++) step(s);
      drain();
      check("tmo_hold_cycles", 16'(n_hold), 16'(TMO));
      check("tmo_sticky", 16'(mdu_timeout), 16'd1);

      // Reset in the second RUN cycle, then a fresh launch.
      s = idle_stim(); s.mdu_req_e = 1; step(s); step(s);
      s.rst_n = 0; step(s);
      s = idle_stim(); s.rst_n = 0; step(s);
      n_start = 0;
      s = idle_stim(); s.mdu_req_e = 1; step(s);
      s.mdu_done = 1; step(s);
      s = idle_stim(); step(s);
      drain();
      check("restart_pulse", 16'(n_start), 16'd1);

      // Random traffic; E stays frozen while an MDU op is in flight.
      for (int i = 0; i < 600; i++) begin
         s = idle_stim();
         s.rs1_d = 5'($urandom_range(0, 3)); s.rs2_d = 5'($urandom_range(0, 3));
         s.rs1_e = 5'($urandom_range(0, 3)); s.rs2_e = 5'($urandom_range(0, 3));
         s.rd_e  = 5'($urandom_range(0, 3)); s.resultsrc_e = 2'($urandom_range(0, 3));
         s.rd_m  = 5'($urandom_range(0, 3)); s.regwrite_m = 1'($urandom_range(0, 1));
         s.rd_w  = 5'($urandom_range(0, 3)); s.regwrite_w = 1'($urandom_range(0, 1));
         s.mdu_done = ($urandom_range(0, 4) == 0);
         if (op_start >= 0) begin
            s.mdu_req_e = 1;
         end else begin
            s.pcsrc_e   = ($urandom_range(0, 4) == 0);
            s.mdu_req_e = ($urandom_range(0, 3) == 0);
         end
         s.rst_n = ($urandom_range(0, 99) != 0);
         step(s);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
